// File: rtl/mem_port_if.sv
`default_nettype none
// ============================================================================
// mem_port_if : MAR/MDR request side and word-RAM req/ack side of the port
// Revision    : 1.0
// ============================================================================
interface mem_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mdr_load;
  logic              busy;
  logic              err_timeout;
  logic              err_overrun;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Controller view
  modport slave (
    input  rd, wr, addr, wdata, mem_rdata, mem_ack,
    output rdata, mdr_load, busy, err_timeout, err_overrun,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Control-unit / RAM view
  modport master (
    output rd, wr, addr, wdata, mem_rdata, mem_ack,
    input  rdata, mdr_load, busy, err_timeout, err_overrun,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// mem_port_ctrl : main-memory port controller, one active + one queued request
// Revision      : 1.0
// ============================================================================
module mem_port_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  wire logic clk,
  input  wire logic reset,
  mem_port_if.slave port
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);
  localparam logic [7:0] c_cnt_max = 8'hFF;

  state_t            r_state,   w_state;
  logic              r_req,     w_req;
  logic              r_we,      w_we;
  logic [ADDR_W-1:0] r_addr,    w_addr;
  logic [DATA_W-1:0] r_wdata,   w_wdata;
  logic              r_q_valid, w_q_valid;
  logic              r_q_we,    w_q_we;
  logic [ADDR_W-1:0] r_q_addr,  w_q_addr;
  logic [DATA_W-1:0] r_q_wdata, w_q_wdata;
  logic [7:0]        r_cnt,     w_cnt;
  logic [DATA_W-1:0] r_rdata,   w_rdata;
  logic              r_mdr_load, w_mdr_load;
  logic              r_err_to,  w_err_to;
  logic              r_err_ov,  w_err_ov;

  logic w_new, w_live, w_ack, w_abort, w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_q_valid  <= 1'b0;
      r_q_we     <= 1'b0;
      r_q_addr   <= '0;
      r_q_wdata  <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_mdr_load <= 1'b0;
      r_err_to   <= 1'b0;
      r_err_ov   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_req      <= w_req;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_q_valid  <= w_q_valid;
      r_q_we     <= w_q_we;
      r_q_addr   <= w_q_addr;
      r_q_wdata  <= w_q_wdata;
      r_cnt      <= w_cnt;
      r_rdata    <= w_rdata;
      r_mdr_load <= w_mdr_load;
      r_err_to   <= w_err_to;
      r_err_ov   <= w_err_ov;
    end
  end

  // Acks only count while mem_req is actually high; IDLE and the gap cycle ignore them.
  assign w_new   = port.rd ^ port.wr;
  assign w_live  = (r_state != IDLE) && r_req;
  assign w_ack   = w_live && port.mem_ack;
  assign w_abort = w_live && !port.mem_ack && (r_cnt == c_timeout);
  assign w_done  = w_ack || w_abort;

  always_comb begin
    w_state    = r_state;
    w_req      = r_req;
    w_we       = r_we;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_q_valid  = r_q_valid;
    w_q_we     = r_q_we;
    w_q_addr   = r_q_addr;
    w_q_wdata  = r_q_wdata;
    w_cnt      = r_cnt;
    w_mdr_load = w_ack && (r_state == RD_WAIT);
    w_rdata    = w_mdr_load ? port.mem_rdata : r_rdata;
    w_err_to   = w_abort;
    w_err_ov   = port.rd && port.wr;

    if (r_state == IDLE || (w_done && !r_q_valid)) begin
      if (w_new) begin
        w_state = port.wr ? WR_WAIT : RD_WAIT;
        w_we    = port.wr;
        w_addr  = port.addr;
        w_wdata = port.wdata;
        w_req   = 1'b1;
        w_cnt   = '0;
      end else begin
        w_state = IDLE;
        w_req   = 1'b0;
      end
    end else if (w_done) begin
      // Promote the queued request; mem_req dips low for one cycle before it issues.
      w_state   = r_q_we ? WR_WAIT : RD_WAIT;
      w_we      = r_q_we;
      w_addr    = r_q_addr;
      w_wdata   = r_q_wdata;
      w_req     = 1'b0;
      w_cnt     = '0;
      w_q_valid = w_new;
      if (w_new) begin
        w_q_we    = port.wr;
        w_q_addr  = port.addr;
        w_q_wdata = port.wdata;
      end
    end else begin
      if (!r_req) begin
        w_req = 1'b1;
      end else if (r_cnt != c_cnt_max) begin
        w_cnt = r_cnt + 8'd1;
      end
      if (w_new) begin
        if (r_q_valid) begin
          w_err_ov = 1'b1;
        end else begin
          w_q_valid = 1'b1;
          w_q_we    = port.wr;
          w_q_addr  = port.addr;
          w_q_wdata = port.wdata;
        end
      end
    end
  end

  assign port.rdata       = r_rdata;
  assign port.mdr_load    = r_mdr_load;
  assign port.busy        = (r_state != IDLE) || r_q_valid;
  assign port.err_timeout = r_err_to;
  assign port.err_overrun = r_err_ov;
  assign port.mem_req     = r_req;
  assign port.mem_we      = r_we;
  assign port.mem_addr    = r_addr;
  assign port.mem_wdata   = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_port_ctrl : directed bench for mem_port_ctrl with a small RAM responder
// Revision         : 1.0
// ============================================================================
module tb_mem_port_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_port_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_port_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .port  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM responder controls, written only by the stimulus process
  logic        ram_en;
  logic        force_ack;
  int          ack_delay;
  logic        pre_go;
  logic [31:0] pre_addr;
  logic [31:0] pre_data;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ack_log [$];
  int          wcnt;

  // Unwritten words read back as A5A5_<low address half>
  always @(negedge clk) begin
    #1;
    if (pre_go) mem[pre_addr] = pre_data;
    if (!ram_en) begin
      bus.mem_ack = force_ack;
      wcnt = 0;
    end else if (bus.mem_req === 1'b1) begin
      if (wcnt == ack_delay) begin
        bus.mem_ack = 1'b1;
        wcnt = 0;
        ack_log.push_back(bus.mem_addr);
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr]
                                                      : {16'hA5A5, bus.mem_addr[15:0]};
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  logic [31:0] load_q [$];
  int          n_ov;
  int          n_to;

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.mdr_load === 1'b1) load_q.push_back(bus.rdata);
      if (bus.err_overrun === 1'b1) n_ov++;
      if (bus.err_timeout === 1'b1) n_to++;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_go   = 1'b1;
    @(negedge clk);
    #2 pre_go = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.mdr_load !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got req=%b busy=%b load=%b want 0 0 0", bus.mem_req, bus.busy, bus.mdr_load); end
    checks++; if (bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.err_timeout !== 1'b0 || bus.err_overrun !== 1'b0) begin
      errors++; $display("FAIL reset_data got rdata=%h addr=%h to=%b ov=%b want 0", bus.rdata, bus.mem_addr, bus.err_timeout, bus.err_overrun); end
    reset = 1'b0;
  endtask

  task automatic test_read;
    preload(32'h10, 32'hDEADBEEF);
    ram_en = 1'b1; ack_delay = 0;
    bus.rd = 1'b1; bus.addr = 32'h10;
    @(negedge clk);
    bus.rd = 1'b0; bus.addr = 32'h0;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10) begin
      errors++; $display("FAIL read_issue got req=%b we=%b addr=%h want 1 0 10", bus.mem_req, bus.mem_we, bus.mem_addr); end
    @(negedge clk);
    checks++; if (bus.mdr_load !== 1'b1 || bus.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_load got load=%b rdata=%h want 1 deadbeef", bus.mdr_load, bus.rdata); end
    checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL read_idle got busy=%b req=%b want 0 0", bus.busy, bus.mem_req); end
    @(negedge clk);
    checks++; if (bus.mdr_load !== 1'b0) begin
      errors++; $display("FAIL read_pulse got load=%b want 0", bus.mdr_load); end
  endtask

  task automatic test_write;
    int ld0;
    int bad;
    ld0 = load_q.size();
    bad = 0;
    ack_delay = 3;
    bus.wr = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.wr = 1'b0; bus.addr = 32'hFFFF_FFFF; bus.wdata = 32'h0BAD_0BAD;
    for (int k = 0; k < 4; k++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL write_stable got %0d unstable cycles want 0", bad); end
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL write_done got req=%b busy=%b want 0 0", bus.mem_req, bus.busy); end
    checks++; if (mem[32'h20] !== 32'h12345678 || load_q.size() !== ld0) begin
      errors++; $display("FAIL write_data got mem=%h loads=%0d want 12345678 %0d", mem[32'h20], load_q.size(), ld0); end
  endtask

  task automatic test_back_to_back;
    int ld0;
    ld0 = load_q.size();
    ack_delay = 2;
    bus.wr = 1'b1; bus.addr = 32'h30; bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b1;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL b2b_wr got we=%b req=%b want 1 1", bus.mem_we, bus.mem_req); end
    @(negedge clk);
    bus.rd = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.err_overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_queued got busy=%b we=%b ov=%b want 1 1 0", bus.busy, bus.mem_we, bus.err_overrun); end
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got req=%b busy=%b want 0 1", bus.mem_req, bus.busy); end
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h30) begin
      errors++; $display("FAIL b2b_rd got req=%b we=%b addr=%h want 1 0 30", bus.mem_req, bus.mem_we, bus.mem_addr); end
    for (int i = 0; i < 20 && load_q.size() == ld0; i++) @(negedge clk);
    checks++; if (load_q.size() !== ld0 + 1 || load_q[load_q.size()-1] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_data got loads=%0d last=%h want %0d cafef00d", load_q.size(), load_q[load_q.size()-1], ld0 + 1); end
  endtask

  task automatic test_overrun;
    int ld0;
    int ov0;
    int ak0;
    ld0 = load_q.size(); ov0 = n_ov; ak0 = ack_log.size();
    ack_delay = 4;
    bus.rd = 1'b1; bus.addr = 32'h40;
    @(negedge clk); bus.addr = 32'h41;
    @(negedge clk); bus.addr = 32'h42;
    @(negedge clk); bus.rd = 1'b0;
    checks++; if (bus.err_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_pulse got %b want 1", bus.err_overrun); end
    @(negedge clk);
    checks++; if (bus.err_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_width got %b want 0", bus.err_overrun); end
    for (int i = 0; i < 40 && bus.busy === 1'b1; i++) @(negedge clk);
    @(negedge clk);
    checks++; if (load_q.size() !== ld0 + 2 || load_q[ld0] !== 32'hA5A50040 || load_q[ld0+1] !== 32'hA5A50041) begin
      errors++; $display("FAIL ovr_order got loads=%0d first=%h second=%h want %0d a5a50040 a5a50041",
                         load_q.size(), load_q[ld0], load_q[ld0+1], ld0 + 2); end
    checks++; if (ack_log.size() !== ak0 + 2 || n_ov !== ov0 + 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ovr_count got acks=%0d ov=%0d busy=%b want %0d %0d 0", ack_log.size(), n_ov, bus.busy, ak0 + 2, ov0 + 1); end
  endtask

  task automatic test_timeout;
    int ld0;
    ld0 = load_q.size();
    ram_en = 1'b0; force_ack = 1'b0;
    bus.rd = 1'b1; bus.addr = 32'h50;
    @(negedge clk);
    bus.rd = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.err_timeout !== 1'b0) begin
      errors++; $display("FAIL to_wait got req=%b to=%b want 1 0", bus.mem_req, bus.err_timeout); end
    @(negedge clk);
    checks++; if (bus.err_timeout !== 1'b1 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL to_abort got to=%b req=%b busy=%b want 1 0 0", bus.err_timeout, bus.mem_req, bus.busy); end
    checks++; if (bus.rdata !== 32'hA5A50041 || load_q.size() !== ld0 || bus.mdr_load !== 1'b0) begin
      errors++; $display("FAIL to_rdata got rdata=%h loads=%0d want a5a50041 %0d", bus.rdata, load_q.size(), ld0); end
    bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 32'h51;
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b0;
    checks++; if (bus.err_overrun !== 1'b1 || bus.err_timeout !== 1'b0 || bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL to_rdwr got ov=%b to=%b req=%b busy=%b want 1 0 0 0",
                         bus.err_overrun, bus.err_timeout, bus.mem_req, bus.busy); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.rd = 1'b1; bus.addr = 32'h60;
    @(negedge clk); bus.addr = 32'h61;
    @(negedge clk); bus.rd = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h60) begin
      errors++; $display("FAIL rst_pre got busy=%b req=%b addr=%h want 1 1 60", bus.busy, bus.mem_req, bus.mem_addr); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 32'h0 || bus.rdata !== 32'h0) begin
      errors++; $display("FAIL rst_async got req=%b busy=%b addr=%h rdata=%h want 0", bus.mem_req, bus.busy, bus.mem_addr, bus.rdata); end
    @(negedge clk);
    reset = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.mdr_load !== 1'b0 || bus.mem_req !== 1'b0 || bus.rdata !== 32'h0) begin
      errors++; $display("FAIL rst_late_ack got busy=%b load=%b req=%b rdata=%h want 0", bus.busy, bus.mdr_load, bus.mem_req, bus.rdata); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    ram_en = 1'b0; force_ack = 1'b0; ack_delay = 0;
    pre_go = 1'b0; pre_addr = '0; pre_data = '0;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_overrun;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
